// File: rtl/updown_sequencer_if.sv
// Host-side control/status bundle for the up/down counter sequencer.
interface updown_sequencer_if #(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned LOOP_W = 4
);
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] up_steps;
  logic [STEP_W-1:0] down_steps;
  logic [LOOP_W-1:0] loops;
  logic              cnt_clr;
  logic              cnt_en;
  logic              updown;
  logic              busy;
  logic              done;
  logic [LOOP_W-1:0] loop_cnt;

  // Host / register-block side
  modport master (
    output start, abort, up_steps, down_steps, loops,
    input  cnt_clr, cnt_en, updown, busy, done, loop_cnt
  );

  // Sequencer side
  modport slave (
    input  start, abort, up_steps, down_steps, loops,
    output cnt_clr, cnt_en, updown, busy, done, loop_cnt
  );
endinterface

// File: rtl/updown_sequencer.sv
// Drives a 4-bit up/down counter through up_steps up / down_steps down, loops times.
module updown_sequencer #(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned LOOP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  updown_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  state_t            eop_state;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] up_q, up_d;
  logic [STEP_W-1:0] down_q, down_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [LOOP_W-1:0] eop_loop;
  logic              last_pass;
  logic              updown_d;
  logic              cnt_clr_q, cnt_en_q, updown_q, busy_q, done_q;

  // Next-state, step/loop counters and config latch
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    up_d     = up_q;
    down_d   = down_q;
    loops_d  = loops_q;
    loop_d   = loop_q;
    updown_d = updown_q;

    // End-of-pass target; loops_q is non-zero whenever UP/DOWN is reachable
    last_pass = (loop_q == loops_q - LOOP_W'(1));
    if (last_pass) begin
      eop_state = S_DONE;
      eop_loop  = loop_q;
    end else begin
      eop_state = (up_q != STEP_W'(0)) ? S_UP : S_DOWN;
      eop_loop  = loop_q + LOOP_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          up_d    = bus.up_steps;
          down_d  = bus.down_steps;
          loops_d = bus.loops;
          loop_d  = LOOP_W'(0);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        step_d = STEP_W'(0);
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (loops_q == LOOP_W'(0) ||
                     (up_q == STEP_W'(0) && down_q == STEP_W'(0))) begin
          state_d = S_DONE;
        end else if (up_q != STEP_W'(0)) begin
          state_d = S_UP;
        end else begin
          state_d = S_DOWN;
        end
      end
      S_UP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (step_q == up_q - STEP_W'(1)) begin
          step_d = STEP_W'(0);
          if (down_q != STEP_W'(0)) begin
            state_d = S_DOWN;
          end else begin
            state_d = eop_state;
            loop_d  = eop_loop;
          end
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DOWN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (step_q == down_q - STEP_W'(1)) begin
          step_d  = STEP_W'(0);
          state_d = eop_state;
          loop_d  = eop_loop;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Direction follows the active phase and holds otherwise
    if (state_d == S_UP) begin
      updown_d = 1'b1;
    end else if (state_d == S_DOWN) begin
      updown_d = 1'b0;
    end
  end

  // State, counters and registered Moore outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      step_q    <= STEP_W'(0);
      up_q      <= STEP_W'(0);
      down_q    <= STEP_W'(0);
      loops_q   <= LOOP_W'(0);
      loop_q    <= LOOP_W'(0);
      cnt_clr_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      updown_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      up_q      <= up_d;
      down_q    <= down_d;
      loops_q   <= loops_d;
      loop_q    <= loop_d;
      cnt_clr_q <= (state_d == S_CLEAR);
      cnt_en_q  <= (state_d == S_UP) || (state_d == S_DOWN);
      updown_q  <= updown_d;
      busy_q    <= (state_d == S_CLEAR) || (state_d == S_UP) || (state_d == S_DOWN);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign bus.cnt_clr  = cnt_clr_q;
  assign bus.cnt_en   = cnt_en_q;
  assign bus.updown   = updown_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.loop_cnt = loop_q;

endmodule
